// File: rtl/vec_decode_issue.sv
// Decode-and-issue stage for the vector SIMD pipeline.
// Instructions are decoded into a single decode register D.
// A per-register pending-write scoreboard holds an instruction in D while it
// has a RAW/WAW hazard. The same stall applies while the outstanding-write
// budget is exhausted.
module vec_decode_issue #(
    parameter int DATA_W   = 32,
    parameter bit SB_EN    = 1'b1,
    parameter int PEND_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_format,
    input  logic [25:0]       in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_alu_op,
    output logic [1:0]        out_alu_src,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_memtoreg,
    output logic              out_illegal,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd
);

    localparam logic [3:0] FMT_I5   = 4'b0001;
    localparam logic [3:0] FMT_I10  = 4'b0010;
    localparam logic [3:0] FMT_3R   = 4'b0100;
    localparam logic [3:0] FMT_MI10 = 4'b1000;

    localparam logic [1:0] SRC_RT    = 2'b00;
    localparam logic [1:0] SRC_IMM5  = 2'b01;
    localparam logic [1:0] SRC_IMM10 = 2'b10;

    localparam logic [5:0] PEND_MAX_C = 6'(PEND_MAX);

    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
        sext5 = {{(DATA_W-5){v[4]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext10(input logic [9:0] v);
        sext10 = {{(DATA_W-10){v[9]}}, v};
    endfunction

    // Decoded fields of the incoming instruction.
    logic [4:0]        dec_rd_s, dec_rs_s, dec_rt_s;
    logic [DATA_W-1:0] dec_imm_s;
    logic [2:0]        dec_alu_op_s;
    logic [1:0]        dec_alu_src_s;
    logic              dec_reg_write_s, dec_mem_read_s, dec_mem_write_s;
    logic              dec_memtoreg_s, dec_illegal_s, dec_use_rs_s, dec_use_rt_s;

    // Decode register D.
    logic              d_valid_r;
    logic [4:0]        rd_r, rs_r, rt_r;
    logic [DATA_W-1:0] imm_r;
    logic [2:0]        alu_op_r;
    logic [1:0]        alu_src_r;
    logic              reg_write_r, mem_read_r, mem_write_r, memtoreg_r;
    logic              illegal_r, use_rs_r, use_rt_r;

    // Scoreboard.
    logic [31:0] pend_r, pend_next_s, set_vec_s, clr_vec_s;
    logic [5:0]  cnt_r, cnt_next_s;
    logic        inc_s, dec_s;

    logic sb_hit_s, full_s, hazard_s, issue_s, load_s;

    // Combinational decode of the format/inst pair; anything unmatched is illegal.
    always_comb begin
        dec_rd_s        = 5'd0;
        dec_rs_s        = 5'd0;
        dec_rt_s        = 5'd0;
        dec_imm_s       = '0;
        dec_alu_op_s    = 3'b000;
        dec_alu_src_s   = SRC_RT;
        dec_reg_write_s = 1'b0;
        dec_mem_read_s  = 1'b0;
        dec_mem_write_s = 1'b0;
        dec_memtoreg_s  = 1'b0;
        dec_use_rs_s    = 1'b0;
        dec_use_rt_s    = 1'b0;
        dec_illegal_s   = 1'b1;
        case (in_format)
            FMT_I5: begin
                if ((in_inst[5:0] == 6'b000110) && (in_inst[25:24] == 2'b00)) begin
                    dec_rd_s        = in_inst[10:6];
                    dec_rs_s        = in_inst[15:11];
                    dec_imm_s       = sext5(in_inst[20:16]);
                    dec_alu_op_s    = {2'b00, in_inst[23]};
                    dec_alu_src_s   = SRC_IMM5;
                    dec_reg_write_s = 1'b1;
                    dec_use_rs_s    = 1'b1;
                    dec_illegal_s   = 1'b0;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            FMT_MI10: begin
                if (in_inst[5:2] == 4'b1000) begin
                    dec_rd_s        = in_inst[10:6];
                    dec_rs_s        = in_inst[15:11];
                    dec_imm_s       = sext10(in_inst[25:16]);
                    dec_alu_src_s   = SRC_IMM10;
                    dec_reg_write_s = 1'b1;
                    dec_mem_read_s  = 1'b1;
                    dec_memtoreg_s  = 1'b1;
                    dec_use_rs_s    = 1'b1;
                    dec_illegal_s   = 1'b0;
                end else if (in_inst[5:2] == 4'b1001) begin
                    dec_rs_s        = in_inst[15:11];
                    dec_rt_s        = in_inst[10:6];
                    dec_imm_s       = sext10(in_inst[25:16]);
                    dec_alu_src_s   = SRC_IMM10;
                    dec_mem_write_s = 1'b1;
                    dec_use_rs_s    = 1'b1;
                    dec_use_rt_s    = 1'b1;
                    dec_illegal_s   = 1'b0;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            FMT_I10: begin
                if (in_inst[25:23] == 3'b110) begin
                    dec_rd_s        = in_inst[10:6];
                    dec_imm_s       = sext10(in_inst[20:11]);
                    dec_alu_src_s   = SRC_IMM10;
                    dec_reg_write_s = 1'b1;
                    dec_illegal_s   = 1'b0;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            FMT_3R: begin
                if ((in_inst[5:0] == 6'b001110) && (in_inst[25:24] == 2'b00)) begin
                    dec_rd_s        = in_inst[10:6];
                    dec_rs_s        = in_inst[15:11];
                    dec_rt_s        = in_inst[20:16];
                    dec_alu_op_s    = {2'b00, in_inst[23]};
                    dec_alu_src_s   = SRC_RT;
                    dec_reg_write_s = 1'b1;
                    dec_use_rs_s    = 1'b1;
                    dec_use_rt_s    = 1'b1;
                    dec_illegal_s   = 1'b0;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Hazard: scoreboard hits (maskable) plus the write budget (never masked).
    always_comb begin
        sb_hit_s = (use_rs_r & pend_r[rs_r]) |
                   (use_rt_r & pend_r[rt_r]) |
                   (reg_write_r & pend_r[rd_r]);
        full_s   = reg_write_r & (cnt_r == PEND_MAX_C);
        hazard_s = (SB_EN & sb_hit_s) | full_s;
    end

    assign out_valid = d_valid_r & ~hazard_s;
    assign in_ready  = ~d_valid_r | (out_valid & out_ready);
    assign issue_s   = out_valid & out_ready;
    assign load_s    = in_valid & in_ready;

    // Next scoreboard state; a same-register set wins over a writeback clear.
    always_comb begin
        set_vec_s = 32'd0;
        clr_vec_s = 32'd0;
        inc_s     = 1'b0;
        dec_s     = 1'b0;
        if (issue_s && reg_write_r) begin
            set_vec_s[rd_r] = 1'b1;
            inc_s           = ~pend_r[rd_r];
        end else begin
            inc_s = 1'b0;
        end
        if (wb_valid && pend_r[wb_rd]) begin
            clr_vec_s[wb_rd] = 1'b1;
            dec_s            = ~(issue_s && reg_write_r && (rd_r == wb_rd));
        end else begin
            dec_s = 1'b0;
        end
        pend_next_s = (pend_r & ~clr_vec_s) | set_vec_s;
        case ({inc_s, dec_s})
            2'b10:   cnt_next_s = cnt_r + 6'd1;
            2'b01:   cnt_next_s = cnt_r - 6'd1;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= 32'd0;
            cnt_r  <= 6'd0;
        end else begin
            pend_r <= pend_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    // Decode register D: load on accept, empty on issue, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_r   <= 1'b0;
            rd_r        <= 5'd0;
            rs_r        <= 5'd0;
            rt_r        <= 5'd0;
            imm_r       <= '0;
            alu_op_r    <= 3'b000;
            alu_src_r   <= 2'b00;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            memtoreg_r  <= 1'b0;
            illegal_r   <= 1'b0;
            use_rs_r    <= 1'b0;
            use_rt_r    <= 1'b0;
        end else if (load_s) begin
            d_valid_r   <= 1'b1;
            rd_r        <= dec_rd_s;
            rs_r        <= dec_rs_s;
            rt_r        <= dec_rt_s;
            imm_r       <= dec_imm_s;
            alu_op_r    <= dec_alu_op_s;
            alu_src_r   <= dec_alu_src_s;
            reg_write_r <= dec_reg_write_s;
            mem_read_r  <= dec_mem_read_s;
            mem_write_r <= dec_mem_write_s;
            memtoreg_r  <= dec_memtoreg_s;
            illegal_r   <= dec_illegal_s;
            use_rs_r    <= dec_use_rs_s;
            use_rt_r    <= dec_use_rt_s;
        end else if (issue_s) begin
            d_valid_r <= 1'b0;
        end
    end

    assign out_rd        = rd_r;
    assign out_rs        = rs_r;
    assign out_rt        = rt_r;
    assign out_imm       = imm_r;
    assign out_alu_op    = alu_op_r;
    assign out_alu_src   = alu_src_r;
    assign out_reg_write = reg_write_r;
    assign out_mem_read  = mem_read_r;
    assign out_mem_write = mem_write_r;
    assign out_memtoreg  = memtoreg_r;
    assign out_illegal   = illegal_r;

endmodule

// File: tb/tb_vec_decode_issue.sv
// Scoreboard-style bench for vec_decode_issue (DATA_W=32, SB_EN=1, PEND_MAX=2).
module tb_vec_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_format;
    logic [25:0] in_inst;
    logic [4:0]  out_rd, out_rs, out_rt, wb_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_alu_op;
    logic [1:0]  out_alu_src;
    logic        out_reg_write, out_mem_read, out_mem_write, out_memtoreg, out_illegal;
    logic        wb_valid;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] expq[$];
    logic [63:0] mon_exp;

    vec_decode_issue #(.DATA_W(32), .SB_EN(1'b1), .PEND_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_memtoreg(out_memtoreg),
        .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [31:0] imm,
                                       input logic [2:0] op, input logic [1:0] src,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic m2r, input logic ill);
        return {7'd0, rd, rs, rt, imm, op, src, rw, mr, mw, m2r, ill};
    endfunction

    function automatic logic [63:0] obs_pack();
        return pk(out_rd, out_rs, out_rt, out_imm, out_alu_op, out_alu_src,
                  out_reg_write, out_mem_read, out_mem_write, out_memtoreg, out_illegal);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction until accepted; push its expected decode on accept.
    task automatic send(input logic [3:0] fmt, input logic [25:0] inst, input logic [63:0] exp);
        bit done = 1'b0;
        in_valid  = 1'b1;
        in_format = fmt;
        in_inst   = inst;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                expq.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
        step();
        wb_valid = 1'b0;
    endtask

    // Output monitor: every handshake pops and compares one expected decode.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("spurious_issue", 64'd1, 64'd0);
            end else begin
                mon_exp = expq.pop_front();
                chk("issue_fields", obs_pack(), mon_exp);
            end
        end
    end

    localparam logic [25:0] ADDV_3_1_2  = 26'h00208CE;
    localparam logic [25:0] ADDVI_4_3_1 = 26'h0011906;
    localparam logic [25:0] LDI_5_M1    = 26'h31FF940;
    localparam logic [25:0] LDI_1_7     = 26'h3003840;
    localparam logic [25:0] LDI_2_M3    = 26'h31FE880;
    localparam logic [25:0] LD_6_0_M2   = 26'h3FE01A0;
    localparam logic [25:0] ST_0_7_5    = 26'h00501E4;
    localparam logic [25:0] ILL_3R      = 26'h00000FF;
    localparam logic [25:0] SUBV_8_9_10 = 26'h08A4A0E;
    localparam logic [25:0] SUBVI_11_2  = 26'h09F12C6;

    logic [63:0] e_addv, e_addvi, e_ld;

    initial begin
        e_addv  = pk(5'd3, 5'd1, 5'd2, 32'd0, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e_addvi = pk(5'd4, 5'd3, 5'd0, 32'd1, 3'b000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e_ld    = pk(5'd6, 5'd0, 5'd0, 32'hFFFFFFFE, 3'b000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset with a valid instruction presented.
        rst = 1'b1; in_valid = 1'b1; in_format = 4'b0100; in_inst = ADDV_3_1_2;
        out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", obs_pack(), 64'd0);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        step();

        // addv v3,v1,v2: one-cycle latency and scoreboard set.
        send(4'b0100, ADDV_3_1_2, e_addv);
        @(negedge clk);
        chk("addv_latency", 64'(out_valid), 64'd1);
        step();
        chk("addv_pend3", 64'(dut.pend_r[3]), 64'd1);
        chk("addv_cnt", 64'(dut.cnt_r), 64'd1);
        wb(5'd3);
        chk("wb3_cnt", 64'(dut.cnt_r), 64'd0);

        // LDI v5,#-1.
        send(4'b0010, LDI_5_M1,
             pk(5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("ldi_nostall", 64'(out_valid), 64'd1);
        step();
        wb(5'd5);

        // RAW: addvi v4,v3 waits for writeback of v3.
        send(4'b0100, ADDV_3_1_2, e_addv);
        send(4'b0001, ADDVI_4_3_1, e_addvi);
        repeat (3) begin
            @(negedge clk);
            chk("raw_hold", 64'(out_valid), 64'd0);
            chk("raw_in_ready", 64'(in_ready), 64'd0);
        end
        wb(5'd3);
        @(negedge clk);
        chk("raw_release", 64'(out_valid), 64'd1);
        step();
        wb(5'd4);

        // Capacity (PEND_MAX=2) with back-pressure.
        send(4'b0010, LDI_1_7,
             pk(5'd1, 5'd0, 5'd0, 32'd7, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send(4'b0010, LDI_2_M3,
             pk(5'd2, 5'd0, 5'd0, 32'hFFFFFFFD, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send(4'b1000, LD_6_0_M2, e_ld);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("cap_hold", 64'(out_valid), 64'd0);
            chk("cap_fields", obs_pack(), e_ld);
        end
        wb(5'd1);
        @(negedge clk);
        chk("cap_release", 64'(out_valid), 64'd1);
        repeat (2) begin
            step();
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_fields", obs_pack(), e_ld);
        end
        step();
        out_ready = 1'b1;
        step();
        chk("cap_pend", 64'(dut.pend_r), 64'h44);

        // ST and illegal never stall on a full budget.
        send(4'b1000, ST_0_7_5,
             pk(5'd0, 5'd0, 5'd7, 32'd5, 3'b000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        chk("st_nostall", 64'(out_valid), 64'd1);
        step();
        send(4'b0100, ILL_3R, pk(5'd0, 5'd0, 5'd0, 32'd0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        chk("ill_nostall", 64'(out_valid), 64'd1);
        step();
        chk("ill_pend", 64'(dut.pend_r), 64'h44);
        chk("ill_cnt", 64'(dut.cnt_r), 64'd2);
        wb(5'd2);
        wb(5'd6);
        wb(5'd20);
        chk("wb_ignore_cnt", 64'(dut.cnt_r), 64'd0);

        // Back-to-back subv / subvi.
        send(4'b0100, SUBV_8_9_10,
             pk(5'd8, 5'd9, 5'd10, 32'd0, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        send(4'b0001, SUBVI_11_2,
             pk(5'd11, 5'd2, 5'd0, 32'hFFFFFFFF, 3'b001, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        step();
        wb(5'd8);
        wb(5'd11);

        // Reset asserted mid-stall drops the held instruction.
        send(4'b0100, ADDV_3_1_2, e_addv);
        send(4'b0001, ADDVI_4_3_1, e_addvi);
        @(negedge clk);
        chk("pre_rst_stall", 64'(out_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        chk("async_rst_cnt", 64'(dut.cnt_r), 64'd0);
        chk("async_rst_fields", obs_pack(), 64'd0);
        expq.delete();
        step();
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst2_idle", 64'(out_valid), 64'd0);
        end

        chk("drain", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
